// File: rtl/spi_display_receiver_pkg.sv
// Shared definitions for the SPI 7-segment display receiver: register
// addresses, Code-B segment patterns and the frame FSM state encoding.
package spi_display_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  // Segment order {A,B,C,D,E,F,G}
  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_DASH  = 7'h01;
  localparam logic [6:0] SEG_E     = 7'h4F;
  localparam logic [6:0] SEG_H     = 7'h37;
  localparam logic [6:0] SEG_L     = 7'h0E;
  localparam logic [6:0] SEG_P     = 7'h67;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Digit addresses map to digit index addr-1
  function automatic logic [2:0] digit_index(input logic [3:0] addr);
    logic [3:0] idx;
    idx = addr - ADDR_DIGIT0;
    return idx[2:0];
  endfunction

endpackage

// File: rtl/spi_display_receiver_code_b_decoder.sv
// Code-B font: 4-bit code to 7-segment pattern {A,B,C,D,E,F,G}.
module code_b_decoder
  import spi_display_receiver_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // Pure lookup of the Code-B font
  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_DASH;
      4'hB: seg = SEG_E;
      4'hC: seg = SEG_H;
      4'hD: seg = SEG_L;
      4'hE: seg = SEG_P;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/spi_display_receiver.sv
// SPI slave emulating a MAX7219-style display driver. Frames are shifted in
// MSB-first on sck rising edges and committed when cs_n rises; the decoded
// register set drives a per-digit segment read port.
module spi_display_receiver
  import spi_display_receiver_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WORD_BITS   = 16
) (
  input  logic       clk,
  input  logic       res,
  input  logic       sck,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       wr_valid,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err,
  output logic [7:0] decode_mode,
  output logic [3:0] intensity,
  output logic [2:0] scan_limit,
  output logic       shutdown_n,
  output logic       display_test,
  input  logic [2:0] rd_digit,
  output logic [7:0] rd_raw,
  output logic [7:0] rd_seg
);

  localparam int CNT_W = $clog2(WORD_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BITS);

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   sck_dly_q, sck_dly_d;
  logic                   cs_dly_q, cs_dly_d;

  logic sck_s, mosi_s, cs_s;
  logic sck_rise, cs_rise, cs_fall;

  state_t               state_q, state_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;

  logic [7:0] digit_q [8];
  logic [7:0] digit_d [8];
  logic [7:0] decode_q, decode_d;
  logic [3:0] intensity_q, intensity_d;
  logic [2:0] scan_q, scan_d;
  logic       shut_q, shut_d;
  logic       test_q, test_d;

  logic [6:0] cb_seg;
  logic       unused_hi;

  assign unused_hi = ^shift_q[WORD_BITS-1:12];

  // Synchronizer chains; cs_n clears to 0 so a frame already in progress
  // when reset releases never looks like a falling edge.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    sck_dly_d   = sck_sync_q[SYNC_STAGES-1];
    cs_dly_d    = cs_sync_q[SYNC_STAGES-1];
  end

  // Synchronizer and edge-detect registers
  always_ff @(posedge clk) begin
    if (res) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '0;
      sck_dly_q   <= 1'b0;
      cs_dly_q    <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sck_dly_q   <= sck_dly_d;
      cs_dly_q    <= cs_dly_d;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_dly_q;
  assign cs_rise  = cs_s & ~cs_dly_q;
  assign cs_fall  = ~cs_s & cs_dly_q;

  // Frame FSM next state, shifter and commit outputs
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    wr_valid  = 1'b0;
    frame_err = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_RECEIVE;
          shift_d   = '0;
          bit_cnt_d = '0;
        end
      end
      ST_RECEIVE: begin
        if (cs_rise) begin
          state_d = ST_COMMIT;
        end else if (sck_rise && !cs_s) begin
          shift_d = {shift_q[WORD_BITS-2:0], mosi_s};
          if (bit_cnt_q != CNT_FULL) bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (bit_cnt_q == CNT_FULL) begin
          wr_valid = 1'b1;
          wr_addr  = shift_q[11:8];
          wr_data  = shift_q[7:0];
        end else begin
          frame_err = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame FSM registers
  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Register-file write decode for committed frames
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) digit_d[i] = digit_q[i];
    decode_d    = decode_q;
    intensity_d = intensity_q;
    scan_d      = scan_q;
    shut_d      = shut_q;
    test_d      = test_q;
    if (wr_valid) begin
      case (wr_addr)
        ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
        ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
          digit_d[digit_index(wr_addr)] = wr_data;
        ADDR_DECODE:    decode_d    = wr_data;
        ADDR_INTENSITY: intensity_d = wr_data[3:0];
        ADDR_SCANLIM:   scan_d      = wr_data[2:0];
        ADDR_SHUTDOWN:  shut_d      = wr_data[0];
        ADDR_TEST:      test_d      = wr_data[0];
        default: ;
      endcase
    end
  end

  // Driver register file
  always_ff @(posedge clk) begin
    if (res) begin
      for (int unsigned i = 0; i < 8; i++) digit_q[i] <= '0;
      decode_q    <= '0;
      intensity_q <= '0;
      scan_q      <= '0;
      shut_q      <= 1'b0;
      test_q      <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 8; i++) digit_q[i] <= digit_d[i];
      decode_q    <= decode_d;
      intensity_q <= intensity_d;
      scan_q      <= scan_d;
      shut_q      <= shut_d;
      test_q      <= test_d;
    end
  end

  assign decode_mode  = decode_q;
  assign intensity    = intensity_q;
  assign scan_limit   = scan_q;
  assign shutdown_n   = shut_q;
  assign display_test = test_q;
  assign rd_raw       = digit_q[rd_digit];

  code_b_decoder u_code_b (
    .code (rd_raw[3:0]),
    .seg  (cb_seg)
  );

  // Segment read port: test overrides blanking, which overrides decoding
  always_comb begin
    rd_seg = rd_raw;
    if (test_q) begin
      rd_seg = 8'hFF;
    end else if (!shut_q || (rd_digit > scan_q)) begin
      rd_seg = 8'h00;
    end else if (decode_q[rd_digit]) begin
      rd_seg = {rd_raw[7], cb_seg};
    end
  end

endmodule

// File: tb/tb_spi_display_receiver.sv
// Scoreboard bench for spi_display_receiver: SPI frames are driven at pin
// level, expected commit events are queued and checked by a monitor, and
// the register set / segment port are compared against a behavioural model.
module tb_spi_display_receiver;

  logic       clk = 1'b0;
  logic       res, sck, mosi, cs_n;
  logic       wr_valid, frame_err;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] decode_mode;
  logic [3:0] intensity;
  logic [2:0] scan_limit;
  logic       shutdown_n, display_test;
  logic [2:0] rd_digit;
  logic [7:0] rd_raw, rd_seg;

  always #5 clk = ~clk;

  spi_display_receiver #(
    .SYNC_STAGES (2),
    .WORD_BITS   (16)
  ) dut (
    .clk          (clk),
    .res          (res),
    .sck          (sck),
    .mosi         (mosi),
    .cs_n         (cs_n),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .frame_err    (frame_err),
    .decode_mode  (decode_mode),
    .intensity    (intensity),
    .scan_limit   (scan_limit),
    .shutdown_n   (shutdown_n),
    .display_test (display_test),
    .rd_digit     (rd_digit),
    .rd_raw       (rd_raw),
    .rd_seg       (rd_seg)
  );

  typedef struct {
    logic       is_err;
    logic [3:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  // Behavioural model of the driver registers
  logic [7:0] m_digit [8];
  logic [7:0] m_decode;
  logic [3:0] m_int;
  logic [2:0] m_scan;
  logic       m_shut, m_test;

  // Code-B font {A..G} for codes 0..F: 0-9, '-', E, H, L, P, blank
  logic [6:0] cb_font [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h01, 7'h4F, 7'h37, 7'h0E, 7'h67, 7'h00};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_digit[i] = 8'h00;
    m_decode = 8'h00;
    m_int    = 4'h0;
    m_scan   = 3'd0;
    m_shut   = 1'b0;
    m_test   = 1'b0;
  endfunction

  function automatic void model_write(input logic [3:0] a, input logic [7:0] d);
    int ai;
    ai = int'(a);
    if (ai >= 1 && ai <= 8) m_digit[ai-1] = d;
    else if (ai == 9)  m_decode = d;
    else if (ai == 10) m_int    = d[3:0];
    else if (ai == 11) m_scan   = d[2:0];
    else if (ai == 12) m_shut   = d[0];
    else if (ai == 15) m_test   = d[0];
  endfunction

  function automatic logic [7:0] model_seg(input int d);
    logic [7:0] b;
    b = m_digit[d];
    if (m_test) return 8'hFF;
    if (!m_shut || d > int'(m_scan)) return 8'h00;
    if (m_decode[d]) return {b[7], cb_font[b[3:0]]};
    return b;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] val, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = val[i];
      cycles(3);
      sck = 1'b1;
      cycles(3);
      sck = 1'b0;
    end
  endtask

  // Drive one full frame and queue its expected commit event
  task automatic spi_frame(input logic [31:0] val, input int nbits);
    ev_t e;
    cs_n = 1'b0;
    cycles(3);
    send_bits(val, nbits);
    cycles(3);
    e.is_err = (nbits < 16);
    e.addr   = val[11:8];
    e.data   = val[7:0];
    exp_q.push_back(e);
    if (!e.is_err) model_write(e.addr, e.data);
    cs_n = 1'b1;
    cycles(2);
    check("commit_early", {31'd0, wr_valid | frame_err}, 32'd0);
    cycles(1);
    check("commit_latency", {31'd0, wr_valid | frame_err}, 32'd1);
    cycles(6);
  endtask

  task automatic check_regs();
    check("decode_mode", decode_mode, m_decode);
    check("intensity", intensity, m_int);
    check("scan_limit", scan_limit, m_scan);
    check("shutdown_n", shutdown_n, m_shut);
    check("display_test", display_test, m_test);
    for (int d = 0; d < 8; d++) begin
      rd_digit = d[2:0];
      #1;
      check($sformatf("rd_raw[%0d]", d), rd_raw, m_digit[d]);
      check($sformatf("rd_seg[%0d]", d), rd_seg, model_seg(d));
    end
    rd_digit = 3'd0;
  endtask

  // Monitor: every commit event must match the head of the expected queue
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!res && (wr_valid || frame_err)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {30'd0, wr_valid, frame_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ev_frame_err", {31'd0, frame_err}, {31'd0, e.is_err});
          check("ev_wr_valid", {31'd0, wr_valid}, {31'd0, ~e.is_err});
          if (!e.is_err) begin
            check("ev_wr_addr", wr_addr, e.addr);
            check("ev_wr_data", wr_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] val;
    int          nb;

    res = 1'b1; sck = 1'b0; mosi = 1'b0; cs_n = 1'b1; rd_digit = 3'd0;
    model_reset();
    cycles(4);
    check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_wr_addr", wr_addr, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check_regs();
    res = 1'b0;
    cycles(4);

    // Power-up sequence and digit decoding
    spi_frame(32'h0C01, 16);
    spi_frame(32'h09FF, 16);
    check("shutdown_on", {31'd0, shutdown_n}, 32'd1);
    check("decode_all", decode_mode, 32'hFF);
    spi_frame(32'h0105, 16);
    spi_frame(32'h0385, 16);
    spi_frame(32'h0B07, 16);
    rd_digit = 3'd0; #1;
    check("seg_digit0_5", rd_seg, 32'h5B);
    rd_digit = 3'd2; #1;
    check("raw_digit2", rd_raw, 32'h85);
    check("seg_digit2_dp5", rd_seg, 32'hDB);
    check_regs();

    // Short frame: error only
    spi_frame(32'h0AAA, 10);
    check_regs();

    // Long frame: only the final 16 bits count
    spi_frame(32'hF0A07, 20);
    check("intensity_long", intensity, 32'h7);
    check_regs();

    // Display test overrides everything, including shutdown
    spi_frame(32'h0F01, 16);
    spi_frame(32'h0C00, 16);
    check_regs();
    spi_frame(32'h0F00, 16);
    check_regs();
    spi_frame(32'h0C01, 16);

    // Randomized frames
    for (int n = 0; n < 30; n++) begin
      val = $urandom;
      nb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 20)) : 16;
      if ($urandom_range(0, 7) == 0) val[11:8] = 4'hF;
      spi_frame(val, nb);
      check_regs();
    end

    // Reset in the middle of a frame; the tail must be ignored
    cs_n = 1'b0;
    cycles(3);
    send_bits(32'h0A, 8);
    res = 1'b1;
    cycles(2);
    res = 1'b0;
    model_reset();
    send_bits(32'h0F, 8);
    cycles(3);
    cs_n = 1'b1;
    cycles(10);
    check_regs();

    // Receiver recovers afterwards
    spi_frame(32'h0C01, 16);
    spi_frame(32'h0B03, 16);
    spi_frame(32'h0477, 16);
    check_regs();

    cycles(10);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
